// File: rtl/memoria_param_if.sv
// ============================================================================
//  Module      : memoria_param_if
//  Description : Bus bundle for memoria_param. It carries the random-access
//                read/write requests, the sequential burst-load control and
//                the registered read data and status flags.
//                  master : drives index, R_B, w_B, DATA, load_start
//                  slave  : drives DATA_OUT, rd_valid, wr_ptr, busy, full
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface memoria_param_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] index;       // random-access address
    logic              R_B;         // read request
    logic              w_B;         // write request
    logic [DATA_W-1:0] DATA;        // write data
    logic              load_start;  // start a burst load from address 0
    logic [DATA_W-1:0] DATA_OUT;    // registered read data
    logic              rd_valid;    // DATA_OUT updated by previous cycle's read
    logic [ADDR_W-1:0] wr_ptr;      // next burst-load address
    logic              busy;        // burst load in progress
    logic              full;        // burst load completed

    modport master (
        output index, R_B, w_B, DATA, load_start,
        input  DATA_OUT, rd_valid, wr_ptr, busy, full
    );

    modport slave (
        input  index, R_B, w_B, DATA, load_start,
        output DATA_OUT, rd_valid, wr_ptr, busy, full
    );
endinterface

`default_nettype wire

// File: rtl/memoria_param.sv
// ============================================================================
//  Module      : memoria_param
//  Description : Single-port-style word memory (2**ADDR_W x DATA_W) with
//                random-access writes/reads and a sequential burst-load mode.
//                States: IDLE (random access), LOAD (writes go to wr_ptr),
//                FULL (every location loaded, random access again).
//                Reads have a fixed 1-cycle latency in every state.
//  Ports       : clk        - clock, rising edge
//                rst_n      - asynchronous active-low reset (memory retained)
//                bus        - memoria_param_if.slave bundle
//  Options     : MEM_BYPASS_EN - when defined, a read and write to the same
//                effective address in one cycle returns the new data;
//                otherwise the old contents are returned.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module memoria_param #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    memoria_param_if.slave        bus
);

    localparam int             c_DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_FULL = 2'd2
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [DATA_W-1:0] r_data_out;
    logic              r_rd_valid;
    logic              r_busy;
    logic              r_full;

    logic [DATA_W-1:0] r_mem [c_DEPTH];

    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_rd_data;

    // Burst mode steers writes to the pointer; otherwise index addresses them.
    assign w_wr_addr = (r_state == S_LOAD) ? r_wr_ptr : bus.index;

`ifdef MEM_BYPASS_EN
    assign w_rd_data = (bus.w_B && (w_wr_addr == bus.index)) ? bus.DATA
                                                               : r_mem[bus.index];
`else
    assign w_rd_data = r_mem[bus.index];
`endif

    // Storage has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (bus.w_B) begin
            r_mem[w_wr_addr] <= bus.DATA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_wr_ptr   <= '0;
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_full     <= 1'b0;
        end else begin
            r_rd_valid <= bus.R_B;
            if (bus.R_B) begin
                r_data_out <= w_rd_data;
            end

            case (r_state)
                S_LOAD: begin
                    // load_start is deliberately ignored here.
                    if (bus.w_B) begin
                        r_wr_ptr <= r_wr_ptr + 1'b1;
                        if (r_wr_ptr == c_LAST) begin
                            r_state <= S_FULL;
                            r_busy  <= 1'b0;
                            r_full  <= 1'b1;
                        end
                    end
                end
                S_IDLE, S_FULL: begin
                    // A coincident write has already gone to index above.
                    if (bus.load_start) begin
                        r_state  <= S_LOAD;
                        r_wr_ptr <= '0;
                        r_busy   <= 1'b1;
                        r_full   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_full  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.DATA_OUT = r_data_out;
    assign bus.rd_valid = r_rd_valid;
    assign bus.wr_ptr   = r_wr_ptr;
    assign bus.busy     = r_busy;
    assign bus.full     = r_full;

endmodule

`default_nettype wire
